// File: rtl/mult_issuer_pkg.sv
// Shared types and constants for the mult32x32 request-side issuer.
package mult_issuer_pkg;

  localparam int unsigned OP_W               = 32;
  localparam int unsigned PROD_W             = 64;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } issuer_state_t;

endpackage

// File: rtl/mult_issuer_timer.sv
// Clearable wait counter; tc flags LIMIT-1 cycles spent while enabled.
module mult_issuer_timer
  import mult_issuer_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count_q, count_d;

  assign tc = en && (count_q == W'(LIMIT - 1));

  // Next count: clear wins, otherwise count up while enabled and saturate at tc.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mult32x32_issuer.sv
// Request-side controller for mult32x32: one job at a time, valid/ready on
// both sides. Define MULT_ISSUER_TIMEOUT_EN to compile in the wait-state
// timeout (sticky err, job dropped); otherwise err stays 0.
module mult32x32_issuer
  import mult_issuer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  output logic              mult_start,
  output logic [OP_W-1:0]   mult_a,
  output logic [OP_W-1:0]   mult_b,
  input  logic              mult_busy,
  input  logic [PROD_W-1:0] mult_product,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_product,
  output logic [CNT_W-1:0]  job_count,
  output logic              err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  issuer_state_t     state_q, state_d;
  logic [OP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [PROD_W-1:0] rsp_product_q, rsp_product_d;
  logic [CNT_W-1:0]  job_count_q, job_count_d;
  logic              req_ready_q, req_ready_d;
  logic              mult_start_q, mult_start_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef MULT_ISSUER_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);

  mult_issuer_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d != state_q),
    .en    (in_wait),
    .tc    (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output decode; outputs are computed for the
  // state being entered so they line up with state_q after the edge.
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_product_d = rsp_product_q;
    job_count_d   = job_count_q;
    err_d         = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_a_d  = req_a;
          op_b_d  = req_b;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (mult_busy) begin
          state_d = WAIT_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!mult_busy) begin
          rsp_product_d = mult_product;
          job_count_d   = job_count_q + 1'b1;
          state_d       = RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    mult_start_d = (state_d == ISSUE);
    rsp_valid_d  = (state_d == RESP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_product_q <= '0;
      job_count_q   <= '0;
      req_ready_q   <= 1'b1;
      mult_start_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_product_q <= rsp_product_d;
      job_count_q   <= job_count_d;
      req_ready_q   <= req_ready_d;
      mult_start_q  <= mult_start_d;
      rsp_valid_q   <= rsp_valid_d;
      err_q         <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mult_start  = mult_start_q;
  assign mult_a      = op_a_q;
  assign mult_b      = op_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign job_count   = job_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mult32x32_issuer.sv
// Directed bench for mult32x32_issuer with a behavioural multiplier model
// (busy for 4 cycles starting the cycle after start, or never when dead).
module tb_mult32x32_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        mult_start;
  logic [31:0] mult_a, mult_b;
  logic        mult_busy;
  logic [63:0] mult_product;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_product;
  logic [1:0]  job_count;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit stub_dead = 1'b0;

  mult32x32_issuer #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (2)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_product (mult_product),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_product  (rsp_product),
    .job_count    (job_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Multiplier model: product is junk while busy, valid once busy drops.
  int          mcnt;
  logic [63:0] pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt         <= 0;
      mult_busy    <= 1'b0;
      mult_product <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else if (mult_start && !stub_dead) begin
      mcnt         <= 4;
      mult_busy    <= 1'b1;
      pend         <= {32'b0, mult_a} * {32'b0, mult_b};
      mult_product <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt         <= 0;
      mult_busy    <= 1'b0;
      mult_product <= pend;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input int hold, input logic [1:0] exp_cnt);
    int n;
    int starts;
    bit stable;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, req_ready, 1);
    req_a = a; req_b = b; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_a = '1; req_b = '1;
    chk({tag, "_start"}, mult_start, 1);
    chk({tag, "_ops"}, {mult_b, mult_a}, {b, a});
    starts = 1; n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
      starts += int'(mult_start);
    end
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_starts"}, starts, 1);
    chk({tag, "_prod"}, rsp_product, exp_p);
    chk({tag, "_cnt"}, job_count, exp_cnt);
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_product !== exp_p || req_ready || mult_a !== a) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, stable, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int err_at;
    bit saw_rsp;
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_ctrl", {mult_start, rsp_valid, err, req_ready}, 4'b0001);
    chk("rst_ops", {mult_a, mult_b}, 64'd0);
    chk("rst_prod", rsp_product, 64'd0);
    chk("rst_cnt", job_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_job("t1", 32'd207223066, 32'd341312304, 64'd70727782098404064, 0, 2'd1);
    run_job("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 10, 2'd2);
    run_job("b0", 32'd3, 32'd5, 64'd15, 0, 2'd3);
    run_job("b1", 32'd0, 32'd123, 64'd0, 0, 2'd0);
    run_job("b2", 32'd1, 32'h8000_0000, 64'h8000_0000, 0, 2'd1);

    // Reset while the multiplier is busy (WAIT_DONE).
    req_a = 32'd7; req_b = 32'd9; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstwd_ctrl", {mult_start, rsp_valid, err, req_ready}, 4'b0001);
    chk("rstwd_ops", {mult_a, mult_b}, 64'd0);
    chk("rstwd_prod", rsp_product, 64'd0);
    chk("rstwd_cnt", job_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job("post_rst", 32'd6, 32'd7, 64'd42, 0, 2'd1);

    // Reset during the start pulse drops it without waiting for a clock.
    req_a = 32'd2; req_b = 32'd2; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("issue_start", mult_start, 1);
    rst_n = 1'b0;
    #1;
    chk("async_start", mult_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiplier that never acknowledges.
    stub_dead = 1'b1;
    run_job_dead: begin
      req_a = 32'd2; req_b = 32'd3; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("dead_start", mult_start, 1);
      err_at = 0; saw_rsp = 1'b0;
      for (n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (rsp_valid) saw_rsp = 1'b1;
        if (err && err_at == 0) err_at = n;
      end
    end
    chk("dead_no_rsp", saw_rsp, 0);
    chk("dead_cnt", job_count, 0);
`ifdef MULT_ISSUER_TIMEOUT_EN
    chk("dead_err", err, 1);
    chk("dead_err_bound", (err_at > 0 && err_at <= 9), 1);
    chk("dead_idle", req_ready, 1);
`else
    chk("dead_err", err, 0);
    chk("dead_stuck", {req_ready, mult_start}, 2'b00);
`endif
    stub_dead = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("recover_err", err, 0);
    run_job("recover", 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE, 0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult32x32_issuer.md
# mult32x32_issuer

Request-side controller for the sequential 32x32 multiplier. It accepts operand pairs on a valid/ready request channel and drives the multiplier's `start`/`a`/`b` inputs. It then tracks the multiplier's `busy` handshake, captures the 64-bit product, and presents it on a valid/ready response channel. It sits between any client datapath and `mult32x32`, which it drives one job at a time.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles tolerated in any wait state before a job is declared failed; only used when the timeout is compiled in.
- `CNT_W`, default 16: width of the completed-job counter.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  request operands valid.
- `req_ready`  output  1  issuer can accept a request.
- `req_a`  input  32  multiplicand.
- `req_b`  input  32  multiplier.
- `mult_start`  output  1  one-cycle start pulse to `mult32x32`.
- `mult_a`  output  32  operand a to `mult32x32`.
- `mult_b`  output  32  operand b to `mult32x32`.
- `mult_busy`  input  1  `busy` from `mult32x32`.
- `mult_product`  input  64  `product` from `mult32x32`.
- `rsp_valid`  output  1  result valid.
- `rsp_ready`  input  1  consumer accepts result.
- `rsp_product`  output  64  captured unsigned product.
- `job_count`  output  `CNT_W`  number of completed jobs; wraps modulo 2^CNT_W.
- `err`  output  1  sticky timeout flag.

## Operation
- State machine `IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> RESP -> IDLE`.
- **IDLE:**
  - `req_ready = 1`.
  - On `req_valid && req_ready`, latch `req_a`/`req_b` into operand registers and go to ISSUE.
- **ISSUE:** `mult_start = 1` for exactly this cycle; go to WAIT_ACK.
- **WAIT_ACK:** wait for `mult_busy == 1`, then go to WAIT_DONE. A `mult_busy` that is already high in ISSUE does not skip this state.
- **WAIT_DONE:**
  - Wait for `mult_busy == 0`.
  - In that cycle, register `mult_product` into `rsp_product` and increment `job_count`.
  - Go to RESP.
- **RESP:**
  - `rsp_valid = 1`, and `rsp_product` is held stable.
  - On `rsp_ready`, go to IDLE.
- `req_ready` is high only in IDLE, so there is never more than one outstanding job.
- `mult_a`/`mult_b` always reflect the operand registers. They stay stable from ISSUE until WAIT_DONE exits.
- The product is unsigned 64-bit and passes through unmodified; there is no arithmetic in this block.
- `req_*` changes outside the IDLE handshake are ignored.

## Timing
- Reset values (asynchronous): state IDLE; `mult_start`, `rsp_valid` and `err` are 0; `mult_a`, `mult_b`, `rsp_product` and `job_count` are all zero.
- Request accepted at edge N:
  - `mult_start` is high in cycle N+1.
  - `rsp_valid` rises one cycle after `mult_busy` is first sampled low in WAIT_DONE.
- Fixed overhead is 3 cycles plus the multiplier's busy duration.
- Back-to-back operation: RESP with `rsp_ready` returns to IDLE. The next request is accepted no earlier than the following cycle.
- Reset mid-job: the block returns to IDLE immediately and the job is lost; `mult_start` drops asynchronously.
- `job_count` wraps from all-ones to 0 without any flag.

## Configuration
- Macro `MULT_ISSUER_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT_ACK and WAIT_DONE and clears on every state change.
  - If it reaches `TIMEOUT_CYCLES - 1` with no transition, `err` is set (sticky until reset) and the state goes to IDLE.
  - On a timeout, no response is produced and `job_count` is unchanged.
- **Undefined:** no counter exists, the wait states wait indefinitely, and `err` is tied to 0.

## Structure
- Package `mult_issuer_pkg` holds:
  - the state enum `issuer_state_t` (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP);
  - the operand width constant (32) and product width constant (64);
  - the default `TIMEOUT_CYCLES`.
- Sub-module `mult_issuer_timer` is the clearable wait counter with terminal-count output. It is instantiated only under `MULT_ISSUER_TIMEOUT_EN`.

## Test plan
- Drive `req_a = 207223066`, `req_b = 341312304` against the real `mult32x32` → exactly one `mult_start` pulse, then `rsp_product = 70727782098404064` and `job_count = 1`.
- `0xFFFFFFFF * 0xFFFFFFFF` with `rsp_ready` held low for 10 cycles → `rsp_valid` and `rsp_product = 0xFFFFFFFE00000001` held stable throughout, with `req_ready = 0`.
- Three back-to-back requests (3×5, 0×123, 1×0x80000000) → results 15, 0, 0x80000000 in order, and `job_count = 3`.
- Assert `reset` low while in WAIT_DONE → all outputs at reset values immediately, and the following job completes correctly.
- Use a stub multiplier that never raises `busy`, with `MULT_ISSUER_TIMEOUT_EN` and `TIMEOUT_CYCLES = 8` → `err = 1` within 8 cycles of `mult_start`, return to IDLE, and no `rsp_valid`.
- Same stub without the macro → the block stays in WAIT_ACK indefinitely and `err` remains 0.
